// File: rtl/multi_slave_spi_master_pkg.sv
// Shared types for the multi-slave SPI master.
//   state_t      : transaction sequencer states
//   MODE0..MODE3 : SPI modes encoded as {cpol, cpha}
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/multi_slave_spi_master_tick_gen.sv
// Half-period tick generator for the SPI master.
//   clk, rst : system clock, asynchronous active-low reset
//   en       : count while a transaction is in progress
//   clr      : load div immediately (start of transaction or abort)
//   div      : half-period length minus one, reloaded on every tick
//   tick     : high for the last clk cycle of each half-period
module spi_tick_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_r;

    // Tick is a decode of the counter so the FSM can act in the same cycle.
    assign tick = en && (cnt_r == {DIV_WIDTH{1'b0}});

    // Down-counter: reload on clear or on each tick, otherwise decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {DIV_WIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= div;
        end else if (en) begin
            if (cnt_r == {DIV_WIDTH{1'b0}}) begin
                cnt_r <= div;
            end else begin
                cnt_r <= cnt_r - DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/multi_slave_spi_master.sv
// SPI master with NUM_SLAVES chip-select lanes, multicast, per-transaction
// word length, SCLK divider, CPOL/CPHA and abort.
//   start/abort          : one-cycle request / terminate
//   tx_data, num_bits    : right-aligned word and its length (MSB first)
//   slave_mask, miso_sel : lanes driven, lane whose miso is captured
//   clk_div, cpol, cpha  : half-period = clk_div+1 cycles, SPI mode
//   miso/sclk/sdi/csb    : per-lane pins (csb active-low)
//   rx_data              : received word, right-aligned, updated at done
//   busy, done, err      : status; done/err are one-cycle pulses
import spi_master_pkg::*;

module multi_slave_spi_master #(
    parameter int NUM_SLAVES = 5,
    parameter int MAX_BITS   = 32,
    parameter int DIV_WIDTH  = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [MAX_BITS-1:0]              tx_data,
    input  logic [$clog2(MAX_BITS+1)-1:0]    num_bits,
    input  logic [NUM_SLAVES-1:0]            slave_mask,
    input  logic [SEL_WIDTH-1:0]             miso_sel,
    input  logic [DIV_WIDTH-1:0]             clk_div,
    input  logic                             cpol,
    input  logic                             cpha,
    input  logic [NUM_SLAVES-1:0]            miso,
    output logic [NUM_SLAVES-1:0]            sclk,
    output logic [NUM_SLAVES-1:0]            sdi,
    output logic [NUM_SLAVES-1:0]            csb,
    output logic [MAX_BITS-1:0]              rx_data,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int NB_W = $clog2(MAX_BITS + 1);

    state_t                state_r;
    logic [MAX_BITS-1:0]   tx_sh_r;
    logic [MAX_BITS-1:0]   rx_sh_r;
    logic [NB_W-1:0]       nbits_r;
    logic [NUM_SLAVES-1:0] mask_r;
    logic [SEL_WIDTH-1:0]  sel_r;
    logic [DIV_WIDTH-1:0]  div_r;
    logic                  cpol_r;
    logic                  cpha_r;
    logic                  aborted_r;
    logic [NB_W:0]         edge_r;
    logic [NUM_SLAVES-1:0] sclk_r;
    logic [NUM_SLAVES-1:0] sdi_r;
    logic [NUM_SLAVES-1:0] csb_r;
    logic [MAX_BITS-1:0]   rx_data_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;

    logic                  request_ok_s;
    logic                  start_go_s;
    logic                  abort_go_s;
    logic [NB_W-1:0]       shamt_s;
    logic [MAX_BITS-1:0]   aligned_s;
    logic [DIV_WIDTH-1:0]  div_s;
    logic                  tick_s;
    logic                  miso_bit_s;
    logic                  sample_s;

    assign request_ok_s = (num_bits != {NB_W{1'b0}}) && (num_bits <= NB_W'(MAX_BITS)) &&
                          (slave_mask != {NUM_SLAVES{1'b0}}) &&
                          (miso_sel < SEL_WIDTH'(NUM_SLAVES));
    assign start_go_s   = (state_r == IDLE) && start && request_ok_s;
    assign abort_go_s   = (state_r != IDLE) && abort;

    // Left-justify the word so the first bit to send is always the MSB.
    assign shamt_s      = NB_W'(MAX_BITS) - num_bits;
    assign aligned_s    = tx_data << shamt_s;

    // The divider must be loaded from the live input on the accepting cycle.
    assign div_s        = (state_r == IDLE) ? clk_div : div_r;
    assign miso_bit_s   = miso[sel_r];

    // Even edge numbers are leading edges; CPHA flips which edge samples.
    assign sample_s     = (~edge_r[0]) ^ cpha_r;

    spi_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy_r),
        .clr  (start_go_s || abort_go_s),
        .div  (div_s),
        .tick (tick_s)
    );

    // Transaction sequencer with registered pin and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            tx_sh_r   <= {MAX_BITS{1'b0}};
            rx_sh_r   <= {MAX_BITS{1'b0}};
            nbits_r   <= {NB_W{1'b0}};
            mask_r    <= {NUM_SLAVES{1'b0}};
            sel_r     <= {SEL_WIDTH{1'b0}};
            div_r     <= {DIV_WIDTH{1'b0}};
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
            aborted_r <= 1'b0;
            edge_r    <= {(NB_W+1){1'b0}};
            sclk_r    <= {NUM_SLAVES{1'b0}};
            sdi_r     <= {NUM_SLAVES{1'b0}};
            csb_r     <= {NUM_SLAVES{1'b1}};
            rx_data_r <= {MAX_BITS{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (abort_go_s) begin
                // Release the bus now; GAP then returns to IDLE with err.
                state_r   <= GAP;
                aborted_r <= 1'b1;
                csb_r     <= {NUM_SLAVES{1'b1}};
                sclk_r    <= {NUM_SLAVES{cpol_r}} & mask_r;
                sdi_r     <= {NUM_SLAVES{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && request_ok_s) begin
                            state_r   <= SETUP;
                            busy_r    <= 1'b1;
                            tx_sh_r   <= aligned_s;
                            rx_sh_r   <= {MAX_BITS{1'b0}};
                            nbits_r   <= num_bits;
                            mask_r    <= slave_mask;
                            sel_r     <= miso_sel;
                            div_r     <= clk_div;
                            cpol_r    <= cpol;
                            cpha_r    <= cpha;
                            aborted_r <= 1'b0;
                            edge_r    <= {(NB_W+1){1'b0}};
                            csb_r     <= ~slave_mask;
                            sclk_r    <= {NUM_SLAVES{cpol}} & slave_mask;
                            sdi_r     <= cpha ? {NUM_SLAVES{1'b0}}
                                              : ({NUM_SLAVES{aligned_s[MAX_BITS-1]}} & slave_mask);
                        end else if (start) begin
                            err_r <= 1'b1;
                        end
                    end
                    SETUP, SHIFT: begin
                        if (tick_s) begin
                            if ((state_r == SHIFT) && (edge_r == {nbits_r, 1'b0})) begin
                                // All 2*num_bits edges done; sclk is back at cpol.
                                state_r <= HOLD;
                            end else begin
                                state_r <= SHIFT;
                                sclk_r  <= sclk_r ^ mask_r;
                                edge_r  <= edge_r + (NB_W+1)'(1);
                                if (sample_s) begin
                                    rx_sh_r <= {rx_sh_r[MAX_BITS-2:0], miso_bit_s};
                                end else if (cpha_r) begin
                                    // CPHA=1 presents the current bit on the leading edge.
                                    sdi_r   <= {NUM_SLAVES{tx_sh_r[MAX_BITS-1]}} & mask_r;
                                    tx_sh_r <= tx_sh_r << 1;
                                end else begin
                                    // CPHA=0 already shows the current bit; move to the next one.
                                    sdi_r   <= {NUM_SLAVES{tx_sh_r[MAX_BITS-2]}} & mask_r;
                                    tx_sh_r <= tx_sh_r << 1;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (tick_s) begin
                            state_r <= GAP;
                            csb_r   <= {NUM_SLAVES{1'b1}};
                            sdi_r   <= {NUM_SLAVES{1'b0}};
                        end
                    end
                    GAP: begin
                        if (tick_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            sclk_r  <= {NUM_SLAVES{1'b0}};
                            done_r  <= ~aborted_r;
                            err_r   <= aborted_r;
                            if (!aborted_r) begin
                                rx_data_r <= rx_sh_r;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        csb_r   <= {NUM_SLAVES{1'b1}};
                        sclk_r  <= {NUM_SLAVES{1'b0}};
                        sdi_r   <= {NUM_SLAVES{1'b0}};
                    end
                endcase
            end
        end
    end

    assign sclk    = sclk_r;
    assign sdi     = sdi_r;
    assign csb     = csb_r;
    assign rx_data = rx_data_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_multi_slave_spi_master.sv
// Self-checking bench for multi_slave_spi_master: vector table driven through
// a scoreboard, plus hand-written abort, reset and start/abort-collision cases.
import spi_master_pkg::*;

module tb_multi_slave_spi_master;

    localparam logic [4:0] MISO_INV = 5'b01010;  // lanes whose slave echoes inverted data

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] tx_data = 32'd0;
    logic [5:0]  num_bits = 6'd0;
    logic [4:0]  slave_mask = 5'd0;
    logic [2:0]  miso_sel = 3'd0;
    logic [7:0]  clk_div = 8'd0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic [4:0]  miso;
    logic [4:0]  sclk, sdi, csb;
    logic [31:0] rx_data;
    logic        busy, done, err;

    assign miso = sdi ^ MISO_INV;

    always #5 clk = ~clk;

    multi_slave_spi_master dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tx_data(tx_data),
        .num_bits(num_bits), .slave_mask(slave_mask), .miso_sel(miso_sel),
        .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .miso(miso), .sclk(sclk),
        .sdi(sdi), .csb(csb), .rx_data(rx_data), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [31:0] tx;
        logic [5:0]  nb;
        logic [4:0]  mask;
        logic [2:0]  sel;
        logic [7:0]  div;
        logic [1:0]  mode;
        bit          exp_err;
        logic [31:0] exp_rx;
    } vec_t;

    typedef struct {
        bit          is_err;
        logic [31:0] rx;
        int          busy;
        bit          chk_bits;
        int          nbits;
        logic [63:0] bits;
    } exp_t;

    vec_t        vecs[10];
    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_done = 0;
    int          seen_done = 0;
    logic [31:0] last_rx = 32'd0;

    // Monitor state
    logic [4:0]  mon_mask = 5'd0;
    logic        mon_cpol = 1'b0;
    logic        mon_cpha = 1'b0;
    int          busy_cnt = 0;
    int          nsamp = 0;
    int          lane_err = 0;
    logic [63:0] bits = 64'd0;
    logic        prev_sclk = 1'b0;
    logic        prev_csb_low = 1'b0;
    int          ref_i;
    exp_t        e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sample just after each rising edge, pop the scoreboard on done/err.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            busy_cnt = 0; nsamp = 0; lane_err = 0; bits = 64'd0;
            prev_sclk = 1'b0; prev_csb_low = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            ref_i = -1;
            for (int i = 4; i >= 0; i--) if (mon_mask[i]) ref_i = i;
            for (int i = 0; i < 5; i++) begin
                if (mon_mask[i] && ref_i >= 0) begin
                    if (sclk[i] !== sclk[ref_i] || sdi[i] !== sdi[ref_i] || csb[i] !== csb[ref_i])
                        lane_err++;
                end else if (csb[i] !== 1'b1 || sclk[i] !== 1'b0 || sdi[i] !== 1'b0) begin
                    lane_err++;
                end
            end
            if (!busy && (csb !== 5'h1f || sclk !== 5'h00 || sdi !== 5'h00)) lane_err++;
            if (ref_i >= 0) begin
                if (prev_csb_low && !csb[ref_i] && sclk[ref_i] != prev_sclk &&
                    sclk[ref_i] == (mon_cpol ^ ~mon_cpha)) begin
                    bits = {bits[62:0], sdi[ref_i]};
                    nsamp++;
                end
                prev_sclk    = sclk[ref_i];
                prev_csb_low = !csb[ref_i];
            end
            if (done || err) begin
                if (done) seen_done++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, done, err}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("pulse_kind", {62'd0, done, err}, e.is_err ? 64'd1 : 64'd2);
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                    chk("rx_data", {32'd0, rx_data}, {32'd0, e.rx});
                    if (e.chk_bits) begin
                        chk("sdi_count", 64'(nsamp), 64'(e.nbits));
                        chk("sdi_bits", bits, e.bits);
                    end
                    chk("lane_activity", 64'(lane_err), 64'd0);
                end
                busy_cnt = 0; nsamp = 0; lane_err = 0; bits = 64'd0;
            end
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t x;
        x.is_err   = v.exp_err;
        x.chk_bits = !v.exp_err;
        x.nbits    = v.exp_err ? 0 : int'(v.nb);
        x.busy     = v.exp_err ? 0 : (2 * int'(v.nb) + 3) * (int'(v.div) + 1);
        x.bits     = {32'd0, v.tx} & ((64'd1 << v.nb) - 64'd1);
        x.rx       = v.exp_err ? last_rx : v.exp_rx;
        if (!v.exp_err) begin
            last_rx = v.exp_rx;
            exp_done++;
        end
        sb_q.push_back(x);
    endtask

    // One-cycle start, then scramble every input to prove they were latched.
    task automatic drive_start(input vec_t v, input bit abort_too);
        @(negedge clk);
        tx_data = v.tx; num_bits = v.nb; slave_mask = v.mask; miso_sel = v.sel;
        clk_div = v.div; cpol = v.mode[1]; cpha = v.mode[0];
        start = 1'b1; abort = abort_too;
        mon_mask = v.exp_err ? 5'd0 : v.mask;
        mon_cpol = v.mode[1]; mon_cpha = v.mode[0];
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        tx_data = $urandom; num_bits = 6'($urandom_range(0, 63));
        slave_mask = 5'($urandom); miso_sel = 3'($urandom); clk_div = 8'($urandom);
        cpol = 1'($urandom); cpha = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 1000; c++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            chk("timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input bit abort_too);
        push_exp(v);
        drive_start(v, abort_too);
        wait_idle();
    endtask

    initial begin
        vec_t va;
        vecs[0] = '{32'h0000_00A5, 6'd8,  5'b00001, 3'd0, 8'd0, MODE0, 1'b0, 32'h0000_00A5};
        vecs[1] = '{32'h0000_C3C3, 6'd16, 5'b00010, 3'd1, 8'd3, MODE3, 1'b0, 32'h0000_3C3C};
        vecs[2] = '{32'h0012_3456, 6'd24, 5'b11110, 3'd3, 8'd1, MODE1, 1'b0, 32'h00ED_CBA9};
        vecs[3] = '{32'hDEAD_BEEF, 6'd32, 5'b00100, 3'd2, 8'd0, MODE2, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{32'hFFFF_FFF1, 6'd1,  5'b10000, 3'd4, 8'd2, MODE0, 1'b0, 32'h0000_0001};
        vecs[5] = '{32'h0000_000F, 6'd8,  5'b00001, 3'd1, 8'd0, MODE0, 1'b0, 32'h0000_00FF};
        vecs[6] = '{32'h0000_00A5, 6'd0,  5'b00001, 3'd0, 8'd0, MODE0, 1'b1, 32'h0};
        vecs[7] = '{32'h0000_00A5, 6'd33, 5'b00001, 3'd0, 8'd0, MODE0, 1'b1, 32'h0};
        vecs[8] = '{32'h0000_00A5, 6'd8,  5'b00000, 3'd0, 8'd0, MODE0, 1'b1, 32'h0};
        vecs[9] = '{32'h0000_00A5, 6'd8,  5'b00001, 3'd5, 8'd0, MODE0, 1'b1, 32'h0};

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk("reset_pins", {49'd0, csb, sclk, sdi}, {49'd0, 5'h1f, 10'h000});
        chk("reset_status", {29'd0, rx_data, busy, done, err}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) apply(vecs[i], 1'b0);

        // Abort at cycle 10 of a 32-bit transfer, with an ignored start while busy.
        va = '{32'hFFFF_0000, 6'd32, 5'b00001, 3'd0, 8'd0, MODE0, 1'b1, 32'h0};
        begin
            exp_t x;
            x.is_err = 1'b1; x.rx = last_rx; x.busy = 11; x.chk_bits = 1'b0;
            x.nbits = 0; x.bits = 64'd0;
            sb_q.push_back(x);
        end
        va.exp_err = 1'b0;  // drive as a real transfer
        drive_start(va, 1'b0);
        repeat (4) @(negedge clk);
        num_bits = 6'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_csb", {59'd0, csb}, {59'd0, 5'h1f});
        wait_idle();

        // Abort in IDLE must not produce err (monitor flags any pulse).
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of SHIFT.
        va = '{32'h8765_4321, 6'd32, 5'b00110, 3'd1, 8'd1, MODE0, 1'b0, 32'h0};
        drive_start(va, 1'b0);
        repeat (20) @(negedge clk);
        chk("busy_before_reset", {63'd0, busy}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_pins", {49'd0, csb, sclk, sdi}, {49'd0, 5'h1f, 10'h000});
        chk("async_reset_status", {29'd0, rx_data, busy, done, err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        last_rx = 32'd0;
        repeat (2) @(negedge clk);

        // Start and abort in the same IDLE cycle: start wins.
        apply(vecs[0], 1'b1);
        apply(vecs[2], 1'b0);

        chk("done_count", 64'(seen_done), 64'(exp_done));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_slave_spi_master.md
Name: multi_slave_spi_master

Overview:
Parametrised SPI master with N independent chip-select lanes, replacing the fixed single-master-plus-external-mux arrangement used for the ADS7950 and AD5453 DACs. Adds per-transaction word length, programmable SCLK divider, CPOL/CPHA mode, multicast to several slaves at once, selectable MISO source, and abort. Sits between the host-command state machine (wire/trigger endpoints) and the board SPI pins.

Parameters:
NUM_SLAVES, 5, number of chip-select lanes (index 0 = ADC, 1..4 = DACs)
MAX_BITS, 32, maximum bits per transaction; width of tx_data/rx_data
DIV_WIDTH, 8, width of clk_div
SEL_WIDTH, 3, width of miso_sel (must hold NUM_SLAVES-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  terminate current transaction
tx_data  in  MAX_BITS  word to send, right-aligned, MSB of num_bits field sent first
num_bits  in  $clog2(MAX_BITS+1)  bits in transaction
slave_mask  in  NUM_SLAVES  one-hot or multi-hot slave select
miso_sel  in  SEL_WIDTH  which miso lane is captured
clk_div  in  DIV_WIDTH  SCLK half-period = clk_div+1 clk cycles
cpol  in  1  SCLK idle level
cpha  in  1  0: sample leading edge; 1: sample trailing edge
miso  in  NUM_SLAVES  per-slave serial data in
sclk  out  NUM_SLAVES  per-slave serial clock
sdi  out  NUM_SLAVES  per-slave serial data out (MOSI)
csb  out  NUM_SLAVES  per-slave chip select, active-low
rx_data  out  MAX_BITS  received word, right-aligned, upper bits zero
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at end of transaction
err  out  1  one-cycle pulse: request rejected or aborted

Behaviour:
- Reset (rst=0, async): csb all 1, sclk all 0, sdi all 0, rx_data 0, busy/done/err 0, state IDLE.
- start in IDLE latches tx_data, num_bits, slave_mask, miso_sel, clk_div, cpol, cpha; later input changes have no effect until next start.
- Reject: num_bits==0, num_bits>MAX_BITS, slave_mask==0, or miso_sel>=NUM_SLAVES -> err pulses next cycle, no pin activity, stays IDLE, done not asserted.
- start while busy ignored (no err).
- States: IDLE -> SETUP (1 half-period, selected csb=0, sclk=cpol, CPHA=0 drives first bit) -> SHIFT (2*num_bits half-periods, SCLK toggles each half-period) -> HOLD (1 half-period, sclk=cpol) -> GAP (1 half-period, csb=1) -> IDLE with done.
- CPHA=0: sample on leading edge, shift on trailing. CPHA=1: shift on leading, sample on trailing. MSB first.
- Only lanes in latched mask are driven; others hold csb=1, sclk=cpol... actually sclk=0, sdi=0. Selected lanes share identical sclk/sdi.
- miso captured only from miso[miso_sel]; rx_data updated once, at done, right-aligned.
- busy high for exactly (2*num_bits+3)*(clk_div+1) cycles starting the cycle after start; done pulses the cycle busy falls.
- Idle sclk on selected lanes equals latched cpol while busy; returns to 0 in IDLE.
- abort while busy: next cycle enters GAP (csb high, sclk=cpol), then IDLE with err pulse, no done, rx_data unchanged. abort in IDLE ignored. abort and start same IDLE cycle: start wins.
- Half-period counter reloads clk_div on every tick; clk_div=0 gives SCLK = clk/2.
- Async reset mid-transaction: all csb high immediately, no done/err.

Decomposition:
- Package spi_master_pkg: state enum (IDLE, SETUP, SHIFT, HOLD, GAP), mode constants (MODE0..MODE3 as {cpol,cpha}).
- Sub-module spi_tick_gen: DIV_WIDTH down-counter producing half-period tick; enable/clear from FSM.

Test Plan:
- Mode 0, clk_div=0, num_bits=8, mask=5'b00001, tx=8'hA5, miso[0] loopback -> sdi 1,0,1,0,0,1,0,1; rx_data=32'h000000A5; busy 19 cycles; done once.
- Mode 3, clk_div=3, num_bits=16, mask=5'b00010, miso[1] fixed 16'h3C3C pattern -> sclk idles high, half-period 4 cycles, busy 140 cycles, rx_data=32'h00003C3C.
- Multicast mask=5'b11110, num_bits=24, tx=24'h123456 -> csb[4:1] low together, identical sdi/sclk on lanes 1..4, csb[0]=1, sclk[0]=0.
- Reject: num_bits=0, then 33, then mask=0, then miso_sel=5 -> err pulse each, csb stays all 1, busy never asserted.
- abort at cycle 10 of 32-bit transfer -> csb high within 2 cycles, err pulse, no done, rx_data unchanged.
- rst low mid-SHIFT -> csb=5'b11111, sclk/sdi=0 asynchronously; after release, a new start completes normally.
